// File: rtl/mult_rr_scheduler_if.sv
// Requester/response bundle for the shared multiplier scheduler.
// The master side is the environment: lanes presenting operands and the
// product consumer. The slave side is the scheduler itself.
interface mult_rr_scheduler_if #(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int N_REQ         = 4,
  parameter int ID_W          = $clog2(N_REQ)
);
  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ-1:0]               req_ready;
  logic [N_REQ*MAC_MIN_WIDTH-1:0] req_a;
  logic [N_REQ*MAC_MIN_WIDTH-1:0] req_b;
  logic                           resp_valid;
  logic                           resp_ready;
  logic [ID_W-1:0]                resp_id;
  logic [2*MAC_MIN_WIDTH-1:0]     resp_prod;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_prod
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_prod
  );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one unsigned W x W multiplier among N_REQ
// requesters. Stage 1 latches the granted operands, stage 2 registers the
// product and presents it with the owning requester's tag.

// Plain unsigned full-width multiplier; kept as its own module so the
// shared instance is explicit.
module multiply #(
  parameter int MAC_MIN_WIDTH = 8
) (
  input  logic [MAC_MIN_WIDTH-1:0]   a_i,
  input  logic [MAC_MIN_WIDTH-1:0]   b_i,
  output logic [2*MAC_MIN_WIDTH-1:0] p_o
);
  assign p_o = (2*MAC_MIN_WIDTH)'(a_i) * (2*MAC_MIN_WIDTH)'(b_i);
endmodule

module mult_rr_scheduler #(
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_MULT_WIDTH = 2*MAC_MIN_WIDTH,
  parameter int N_REQ          = 4,
  parameter int ID_W           = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  mult_rr_scheduler_if.slave  bus,
  output logic                busy
);
  localparam int CW = ID_W + 1;  // room for rr_ptr + offset before wrap

  // Round-robin pointer: first requester to consider next cycle
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Stage 1: latched operands of the granted requester
  logic                     s1_valid_q;
  logic [MAC_MIN_WIDTH-1:0] s1_a_q, s1_b_q;
  logic [ID_W-1:0]          s1_id_q;

  // Stage 2: registered product, drives the response channel
  logic                      resp_valid_q;
  logic [ID_W-1:0]           resp_id_q;
  logic [MAC_MULT_WIDTH-1:0] resp_prod_q;

  logic s1_adv, s2_adv;
  logic raw_any, grant_any;
  logic [ID_W-1:0] grant_idx;

  logic [ID_W-1:0]          cand_idx [N_REQ];
  logic [N_REQ-1:0]         cand_valid;
  logic [MAC_MIN_WIDTH-1:0] op_a [N_REQ];
  logic [MAC_MIN_WIDTH-1:0] op_b [N_REQ];
  logic [MAC_MULT_WIDTH-1:0] mult_p;

  // A full S2 that is not being drained blocks S2, and in turn a full S1.
  assign s2_adv = !resp_valid_q || bus.resp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Candidate gi is the requester gi places after rr_ptr; the wrap is done
  // by explicit subtraction so non-power-of-two N_REQ wraps at N_REQ-1.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    logic [CW-1:0] sum;
    assign sum            = {1'b0, rr_ptr_q} + CW'(gi);
    assign cand_idx[gi]   = (sum >= CW'(N_REQ)) ? ID_W'(sum - CW'(N_REQ))
                                                : sum[ID_W-1:0];
    assign cand_valid[gi] = bus.req_valid[cand_idx[gi]];
    assign op_a[gi]       = bus.req_a[gi*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
    assign op_b[gi]       = bus.req_b[gi*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
    assign bus.req_ready[gi] = grant_any && (grant_idx == ID_W'(gi));
  end

  // Pick the nearest valid candidate in rotated order (lowest offset wins)
  always_comb begin
    raw_any   = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        raw_any   = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
  end

  // No grant while S1 cannot take a new item or while reset is asserted.
  assign grant_any = raw_any && s1_adv && !rst;

  assign rr_ptr_d = !grant_any                         ? rr_ptr_q :
                    (grant_idx == ID_W'(N_REQ - 1))    ? '0       :
                                                         grant_idx + 1'b1;

  // Advance the pointer past each granted requester
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Stage 1 captures the granted operands whenever it is allowed to move
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= grant_any;
      s1_a_q     <= op_a[grant_idx];
      s1_b_q     <= op_b[grant_idx];
      s1_id_q    <= grant_idx;
    end
  end

  multiply #(
    .MAC_MIN_WIDTH(MAC_MIN_WIDTH)
  ) u_mult (
    .a_i(s1_a_q),
    .b_i(s1_b_q),
    .p_o(mult_p)
  );

  // Stage 2 registers the product; holds steady under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_prod_q  <= '0;
    end else if (s2_adv) begin
      resp_valid_q <= s1_valid_q;
      resp_id_q    <= s1_id_q;
      resp_prod_q  <= mult_p;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_prod  = resp_prod_q;
  assign busy           = s1_valid_q || resp_valid_q;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Randomized and directed bench for mult_rr_scheduler. A queue-based model
// of in-flight products predicts grants, responses and busy every cycle.
module tb_mult_rr_scheduler;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  logic busy4, busy3;

  always #5 clk = ~clk;

  mult_rr_scheduler_if #(.MAC_MIN_WIDTH(W), .N_REQ(N)) bus4 ();
  mult_rr_scheduler_if #(.MAC_MIN_WIDTH(W), .N_REQ(3)) bus3 ();

  mult_rr_scheduler #(.MAC_MIN_WIDTH(W), .N_REQ(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4),
    .busy(busy4)
  );

  mult_rr_scheduler #(.MAC_MIN_WIDTH(W), .N_REQ(3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3),
    .busy(busy3)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           id;
    bit           vis;  // already past stage 1, i.e. on the response port
  } item_t;

  item_t q[$];
  int    ptr;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_accept = 0;

  // Stimulus state: mode 0 holds requests, 1 drops on accept, 2 random refill
  bit           vld [N];
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  bit           rr;
  int           mode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus4.req_valid[i]       = vld[i];
      bus4.req_a[i*W +: W]    = opa[i];
      bus4.req_b[i*W +: W]    = opb[i];
    end
    bus4.resp_ready = rr;
  endtask

  // One clock of the 4-requester DUT: check outputs, then advance the model.
  task automatic cycle();
    int           g;
    bit           can;
    bit           exp_rv;
    logic [N-1:0] exp_rdy;
    logic [15:0]  exp_p;
    drive();
    #1;
    g   = -1;
    can = !rst && !(q.size() == 2 && !rr);
    if (can) begin
      for (int k = 0; k < N; k++) begin
        if (vld[(ptr + k) % N]) begin
          g = (ptr + k) % N;
          break;
        end
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = (q.size() > 0) && q[0].vis;
    chk("req_ready", 32'(bus4.req_ready), 32'(exp_rdy));
    chk("resp_valid", 32'(bus4.resp_valid), 32'(exp_rv));
    chk("busy", 32'(busy4), 32'(q.size() > 0));
    if (exp_rv && bus4.resp_valid) begin
      exp_p = 16'(q[0].a) * 16'(q[0].b);
      chk("resp_id", 32'(bus4.resp_id), 32'(q[0].id));
      chk("resp_prod", 32'(bus4.resp_prod), 32'(exp_p));
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      ptr = 0;
    end else begin
      if (exp_rv && rr) begin
        $display("resp id=%0d a=%0d b=%0d prod=%0d", q[0].id, q[0].a, q[0].b, 16'(q[0].a) * 16'(q[0].b));
        void'(q.pop_front());
      end
      if (q.size() > 0) q[0].vis = 1'b1;
      if (g >= 0) begin
        q.push_back('{a: opa[g], b: opb[g], id: g, vis: 1'b0});
        ptr = (g + 1) % N;
        n_accept++;
        if (mode == 1) vld[g] = 1'b0;
        if (mode == 2) begin
          vld[g] = 1'($urandom_range(0, 1));
          opa[g] = W'($urandom);
          opb[g] = W'($urandom);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_all(input bit v);
    for (int i = 0; i < N; i++) vld[i] = v;
  endtask

  initial begin
    int acc0;
    int grant3;
    int ids3 [8];
    logic [2:0] exp3;

    rst  = 1'b1;
    rst3 = 1'b1;
    rr   = 1'b1;
    mode = 0;
    ptr  = 0;
    for (int i = 0; i < N; i++) begin
      opa[i] = W'(i + 1);
      opb[i] = W'(3);
    end
    set_all(1'b1);
    bus3.req_valid  = '0;
    bus3.req_a      = '0;
    bus3.req_b      = '0;
    bus3.resp_ready = 1'b1;
    @(negedge clk);

    // Reset with every requester asking: nothing may be granted
    repeat (3) cycle();
    chk("rst_id", 32'(bus4.resp_id), 32'd0);
    chk("rst_prod", 32'(bus4.resp_prod), 32'd0);

    // Round robin, all continuously valid: first grant goes to 0
    rst = 1'b0;
    repeat (10) cycle();
    set_all(1'b0);
    repeat (3) cycle();

    // Single request from requester 2 with the largest operands
    mode   = 1;
    vld[2] = 1'b1;
    opa[2] = 8'hFF;
    opb[2] = 8'hFF;
    repeat (5) cycle();

    // Backpressure: only two items may enter while the consumer stalls
    mode = 0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b1;
      opa[i] = W'($urandom);
      opb[i] = W'($urandom);
    end
    rr   = 1'b0;
    acc0 = n_accept;
    repeat (5) cycle();
    chk("bp_accepts", 32'(n_accept - acc0), 32'd2);
    rr = 1'b1;
    repeat (4) cycle();
    set_all(1'b0);
    repeat (3) cycle();

    // Reset while both stages are full: in-flight data is dropped
    rr = 1'b0;
    set_all(1'b1);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_all(1'b0);
    rr  = 1'b1;
    repeat (4) cycle();
    set_all(1'b1);
    mode = 1;
    repeat (6) cycle();

    // Randomized traffic with random backpressure
    mode = 2;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1;
          opa[i] = W'($urandom);
          opb[i] = W'($urandom);
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      cycle();
    end
    mode = 0;
    set_all(1'b0);
    rr = 1'b1;
    repeat (4) cycle();

    // Three requesters: park the pointer at 2, then only 2 and 0 ask
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus3.req_a[i*W +: W] = W'(i + 5);
      bus3.req_b[i*W +: W] = W'(7);
    end
    for (int c = 0; c < 8; c++) begin
      bus3.req_valid = (c == 0) ? 3'b010 : 3'b101;
      grant3  = (c == 0) ? 1 : ((c % 2 == 1) ? 2 : 0);
      ids3[c] = grant3;
      exp3    = 3'b001 << grant3;
      #1;
      chk("wrap_ready", 32'(bus3.req_ready), 32'(exp3));
      if (c >= 2) begin
        chk("wrap_valid", 32'(bus3.resp_valid), 32'd1);
        chk("wrap_id", 32'(bus3.resp_id), 32'(ids3[c-2]));
        chk("wrap_prod", 32'(bus3.resp_prod), 32'((ids3[c-2] + 5) * 7));
        $display("resp3 id=%0d prod=%0d", bus3.resp_id, bus3.resp_prod);
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one unsigned `multiply` instance (W x W -> 2W) among N_REQ requesters through a 2-stage pipeline.
- A round-robin arbiter selects one requester per cycle and latches its operands into stage 1 (S1).
- The product is registered in stage 2 (S2) and returned on a single tagged response channel.
- Sits between the MAC lane front-ends and the shared multiplier, so lanes can time-share the multiplier area.

Parameters:
- MAC_MIN_WIDTH, 8, operand width W; passed through to `multiply`.
- MAC_MULT_WIDTH, 2*MAC_MIN_WIDTH, product width.
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ), width of the requester tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  N_REQ*MAC_MIN_WIDTH  operand A; requester i occupies bits [i*W +: W].
- req_b  in  N_REQ*MAC_MIN_WIDTH  operand B; same packing as req_a.
- resp_valid  out  1  product valid.
- resp_ready  in  1  consumer accept.
- resp_id  out  ID_W  index of the requester that owns resp_prod.
- resp_prod  out  MAC_MULT_WIDTH  A*B, unsigned, full width, never truncated.
- busy  out  1  high when S1 or S2 holds data.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - s1_valid=0, resp_valid=0, resp_id=0, resp_prod=0, rr_ptr=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation discards in-flight S1/S2 contents; no response is produced for them.
- Transfer rules:
  - A request transfer occurs when req_valid[i] && req_ready[i].
  - A response transfer occurs when resp_valid && resp_ready.
- Stall logic:
  - s2_adv = !resp_valid || resp_ready.
  - s1_adv = !s1_valid || s2_adv.
- Arbitration (combinational):
  - When s1_adv=1, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping mod N_REQ.
  - req_ready = one-hot(grant). With no valid requester, or s1_adv=0, req_ready is all zero.
  - req_ready must not depend on resp_ready except through s2_adv.
- Pointer update:
  - On a grant to i, rr_ptr <= (i+1) mod N_REQ at that edge.
  - With no grant, rr_ptr holds.
  - When N_REQ is not a power of two, the wrap at N_REQ-1 -> 0 is explicit.
- S1 register:
  - On s1_adv: s1_valid <= grant_any; s1_a, s1_b, s1_id <= the granted requester's operands and index.
  - When !s1_adv, S1 holds.
- S2 register:
  - On s2_adv: resp_valid <= s1_valid; resp_prod <= multiply(s1_a, s1_b); resp_id <= s1_id.
  - When !s2_adv, S2 holds; outputs stay stable while resp_valid && !resp_ready.
- Latency and throughput:
  - Request accepted at edge k -> resp_valid high after edge k+1, i.e. 2-cycle latency.
  - Sustained throughput is 1 product/cycle with resp_ready held high.
- Simultaneous events:
  - Response transfer and new grant in the same cycle are allowed; the pipeline advances fully.
  - A requester holding req_valid with changing operands is illegal (AXI-style rule); the block samples only on transfer.
- Fairness: a continuously valid requester is granted within N_REQ grants.
- busy = s1_valid || resp_valid.

Test Plan:
- Reset check: rst high 3 cycles with all req_valid=1 -> req_ready=0, resp_valid=0, busy=0; first grant after release goes to requester 0.
- Single request, N_REQ=4: req 2 presents A=8'hFF, B=8'hFF, resp_ready=1 -> resp_valid 2 cycles after accept, resp_prod=16'hFE01, resp_id=2.
- Round-robin order: all 4 valid continuously, operands A=i+1, B=3 -> grant order 0,1,2,3,0,...; products 3,6,9,12 with matching ids, one per cycle.
- Backpressure: hold resp_ready=0 for 5 cycles with 3 requesters valid -> exactly 2 accepts (S1, S2 fill), then req_ready=0; resp_prod stable. Release -> no loss or duplication; id order preserved.
- Pointer wrap, N_REQ=3: only req 2 and req 0 valid, pointer at 2 -> grants alternate 2,0,2,0.
- Mid-operation reset: assert rst one cycle while S1 and S2 are both full -> no response emitted afterwards, busy=0, rr_ptr=0.
